stage_sequencer: RTL and testbench

Game-flow controller that sequences the per-level play datapath: it loads the level, runs the countdown, accumulates money from delivered objects, decides pass or fail against a per-level target, and advances levels. It sits between the menu/top FSM and the level datapath. It drives the level datapath's enable and load strobes, and supplies timer, money and target values to the HUD.

---
 rtl/stage_sequencer_if.sv | 39 +++
 rtl/stage_sequencer.sv | 139 +++++++++++++
 tb/tb_stage_sequencer.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/stage_sequencer_if.sv
// Handshake bundle between the game-flow sequencer and its surroundings.
// The master side is the sequencer. The slave side is the menu, timer, hook and HUD.
interface stage_sequencer_if #(
    parameter int NUM_LEVELS = 4,
    parameter int MONEY_W    = 16
);
    localparam int LEVEL_W = (NUM_LEVELS > 1) ? $clog2(NUM_LEVELS) : 1;

    // Requests and events coming into the sequencer
    logic               startGame;
    logic               nextLevel;
    logic               oneSecPulse;
    logic               collectValid;
    logic [MONEY_W-1:0] collectValue;
    logic               allCollected;

    // Control strobes and HUD values produced by the sequencer
    logic               levelEnable;
    logic               loadPulse;
    logic [LEVEL_W-1:0] levelIndex;
    logic [6:0]         timeLeft;
    logic [MONEY_W-1:0] money;
    logic [MONEY_W-1:0] target;
    logic               stagePassed;
    logic               stageFailed;
    logic               lastLevelEnded;

    modport master (
        input  startGame, nextLevel, oneSecPulse, collectValid, collectValue, allCollected,
        output levelEnable, loadPulse, levelIndex, timeLeft, money, target,
               stagePassed, stageFailed, lastLevelEnded
    );

    modport slave (
        output startGame, nextLevel, oneSecPulse, collectValid, collectValue, allCollected,
        input  levelEnable, loadPulse, levelIndex, timeLeft, money, target,
               stagePassed, stageFailed, lastLevelEnded
    );
endinterface

// File: rtl/stage_sequencer.sv
// Game-flow controller. It loads each level, runs the countdown and accumulates
// money. It then grades the level against its target and advances to the next level.
module stage_sequencer #(
    parameter int NUM_LEVELS  = 4,
    parameter int MAX_TIME    = 60,
    parameter int MONEY_W     = 16,
    parameter int TARGET_BASE = 650,
    parameter int TARGET_STEP = 400
) (
    input  logic              clk,
    input  logic              resetN,
    stage_sequencer_if.master bus
);
    localparam int                 LEVEL_W     = (NUM_LEVELS > 1) ? $clog2(NUM_LEVELS) : 1;
    localparam logic [LEVEL_W-1:0] LAST_LEVEL  = LEVEL_W'(NUM_LEVELS - 1);
    localparam logic [6:0]         TIME_INIT   = 7'(MAX_TIME);
    localparam logic [MONEY_W-1:0] TARGET_INIT = MONEY_W'(TARGET_BASE);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_PLAY, S_EVAL, S_PASSED, S_FAILED, S_DONE
    } state_t;

    // Money target for a given level index
    function automatic logic [MONEY_W-1:0] target_for(input logic [LEVEL_W-1:0] idx);
        return MONEY_W'(TARGET_BASE + int'(32'(idx)) * TARGET_STEP);
    endfunction

    state_t             r_state;
    logic               r_level_enable;
    logic               r_load_pulse;
    logic [LEVEL_W-1:0] r_level;
    logic [6:0]         r_time_left;
    logic [MONEY_W-1:0] r_money;
    logic [MONEY_W-1:0] r_target;
    logic               r_stage_passed;
    logic               r_stage_failed;
    logic               r_last_level_ended;

    logic [MONEY_W:0]   w_sum;
    logic [MONEY_W-1:0] w_money_next;
    logic [6:0]         w_time_next;
    logic               w_timeout;
    logic [LEVEL_W-1:0] w_level_inc;

    // Next-value arithmetic used during PLAY: saturating money and a countdown that stops at zero
    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch can be inferred.
        w_money_next = r_money;
        w_time_next  = r_time_left;
        w_sum        = {1'b0, r_money} + {1'b0, bus.collectValue};
        if (bus.collectValid) begin
            w_money_next = w_sum[MONEY_W] ? '1 : w_sum[MONEY_W-1:0];
        end
        if (bus.oneSecPulse && (r_time_left != 7'd0)) begin
            w_time_next = r_time_left - 7'd1;
        end
        w_timeout   = bus.oneSecPulse && (r_time_left == 7'd1);
        w_level_inc = r_level + 1'b1;
    end

    // Game-flow FSM with all outputs registered
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            r_state            <= S_IDLE;
            r_level_enable     <= 1'b0;
            r_load_pulse       <= 1'b0;
            r_level            <= '0;
            r_time_left        <= '0;
            r_money            <= '0;
            r_target           <= TARGET_INIT;
            r_stage_passed     <= 1'b0;
            r_stage_failed     <= 1'b0;
            r_last_level_ended <= 1'b0;
        end else begin
            r_load_pulse <= 1'b0;
            case (r_state)
                S_IDLE, S_FAILED, S_DONE: begin
                    if (bus.startGame) begin
                        r_state            <= S_LOAD;
                        r_level            <= '0;
                        r_target           <= TARGET_INIT;
                        r_money            <= '0;
                        r_time_left        <= TIME_INIT;
                        r_load_pulse       <= 1'b1;
                        r_stage_failed     <= 1'b0;
                        r_last_level_ended <= 1'b0;
                    end
                end
                S_LOAD: begin
                    r_state        <= S_PLAY;
                    r_level_enable <= 1'b1;
                end
                S_PLAY: begin
                    r_time_left <= w_time_next;
                    r_money     <= w_money_next;
                    if (w_timeout || bus.allCollected) begin
                        r_state        <= S_EVAL;
                        r_level_enable <= 1'b0;
                    end
                end
                S_EVAL: begin
                    if (r_money >= r_target) begin
                        r_state        <= S_PASSED;
                        r_stage_passed <= 1'b1;
                    end else begin
                        r_state        <= S_FAILED;
                        r_stage_failed <= 1'b1;
                    end
                end
                S_PASSED: begin
                    if (r_level == LAST_LEVEL) begin
                        r_state            <= S_DONE;
                        r_stage_passed     <= 1'b0;
                        r_last_level_ended <= 1'b1;
                    end else if (bus.nextLevel) begin
                        r_state        <= S_LOAD;
                        r_level        <= w_level_inc;
                        r_target       <= target_for(w_level_inc);
                        r_time_left    <= TIME_INIT;
                        r_load_pulse   <= 1'b1;
                        r_stage_passed <= 1'b0;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.levelEnable    = r_level_enable;
    assign bus.loadPulse      = r_load_pulse;
    assign bus.levelIndex     = r_level;
    assign bus.timeLeft       = r_time_left;
    assign bus.money          = r_money;
    assign bus.target         = r_target;
    assign bus.stagePassed    = r_stage_passed;
    assign bus.stageFailed    = r_stage_failed;
    assign bus.lastLevelEnded = r_last_level_ended;
endmodule

// File: tb/tb_stage_sequencer.sv
// Directed bench for stage_sequencer. One 4-level and one 2-level instance share the same stimulus.
module tb_stage_sequencer;
    logic        clk = 1'b0;
    logic        resetN;
    logic        start_game, next_level, one_sec, collect_valid, all_collected;
    logic [15:0] collect_value;
    int          n_checks = 0;
    int          n_fail   = 0;
    int          en_cnt;

    always #5 clk = ~clk;

    stage_sequencer_if #(.NUM_LEVELS(4), .MONEY_W(16)) if4 ();
    stage_sequencer_if #(.NUM_LEVELS(2), .MONEY_W(16)) if2 ();

    assign if4.startGame    = start_game;
    assign if4.nextLevel    = next_level;
    assign if4.oneSecPulse  = one_sec;
    assign if4.collectValid = collect_valid;
    assign if4.collectValue = collect_value;
    assign if4.allCollected = all_collected;
    assign if2.startGame    = start_game;
    assign if2.nextLevel    = next_level;
    assign if2.oneSecPulse  = one_sec;
    assign if2.collectValid = collect_valid;
    assign if2.collectValue = collect_value;
    assign if2.allCollected = all_collected;

    stage_sequencer #(.NUM_LEVELS(4)) dut4 (.clk(clk), .resetN(resetN), .bus(if4));
    stage_sequencer #(.NUM_LEVELS(2)) dut2 (.clk(clk), .resetN(resetN), .bus(if2));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input logic s, input logic n, input logic t, input logic c,
                         input logic [15:0] v);
        start_game = s; next_level = n; one_sec = t; collect_valid = c; collect_value = v;
        cycle();
        start_game = 0; next_level = 0; one_sec = 0; collect_valid = 0; collect_value = '0;
    endtask

    task automatic tick_n(input int n);
        for (int i = 0; i < n; i++) pulse(0, 0, 1, 0, 16'd0);
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_en"},     32'(if4.levelEnable), 0);
        check({tag, "_load"},   32'(if4.loadPulse), 0);
        check({tag, "_lvl"},    32'(if4.levelIndex), 0);
        check({tag, "_time"},   32'(if4.timeLeft), 0);
        check({tag, "_money"},  32'(if4.money), 0);
        check({tag, "_target"}, 32'(if4.target), 650);
        check({tag, "_flags"},  32'({if4.stagePassed, if4.stageFailed, if4.lastLevelEnded}), 0);
        check({tag, "_lvl2"},   32'(if2.levelIndex), 0);
    endtask

    initial begin
        resetN = 0; start_game = 0; next_level = 0; one_sec = 0;
        collect_valid = 0; all_collected = 0; collect_value = '0;
        #12;
        check_idle("por");
        resetN = 1;
        cycle();

        // Asynchronous reset in the middle of a level
        pulse(1, 0, 0, 0, 16'd0);
        cycle();
        pulse(0, 0, 0, 1, 16'd500);
        tick_n(23);
        check("mid_time",  32'(if4.timeLeft), 37);
        check("mid_money", 32'(if4.money), 500);
        resetN = 0;
        #2;
        check_idle("rst_mid");
        resetN = 1;
        cycle();

        // Level 0 ends one short of the target and must fail
        pulse(1, 0, 0, 0, 16'd0);
        check("g1_load", 32'(if4.loadPulse), 1);
        cycle();
        check("g1_en", 32'(if4.levelEnable), 1);
        pulse(0, 0, 1, 1, 16'd600);            // tick and collect together
        check("g1_both_time",  32'(if4.timeLeft), 59);
        check("g1_both_money", 32'(if4.money), 600);
        pulse(0, 0, 0, 1, 16'd49);
        tick_n(59);
        check("g1_eval_time", 32'(if4.timeLeft), 0);
        check("g1_eval_en",   32'(if4.levelEnable), 0);
        check("g1_eval_fail", 32'(if4.stageFailed), 0);
        cycle();
        check("g1_failed", 32'(if4.stageFailed), 1);
        check("g1_passed", 32'(if4.stagePassed), 0);
        check("g1_money",  32'(if4.money), 649);
        pulse(0, 0, 1, 1, 16'd100);            // ignored outside PLAY
        check("g1_ign_money", 32'(if4.money), 649);
        check("g1_ign_time",  32'(if4.timeLeft), 0);
        pulse(0, 1, 0, 0, 16'd0);              // nextLevel ignored in FAILED
        check("g1_ign_next", 32'(if4.stageFailed), 1);
        pulse(1, 0, 0, 0, 16'd0);
        check("rs_load",  32'(if4.loadPulse), 1);
        check("rs_lvl",   32'(if4.levelIndex), 0);
        check("rs_money", 32'(if4.money), 0);
        check("rs_time",  32'(if4.timeLeft), 60);
        check("rs_fail",  32'(if4.stageFailed), 0);

        // Level 0: a collect on the final tick reaches the target exactly
        cycle();
        check("g2_load_off", 32'(if4.loadPulse), 0);
        pulse(0, 0, 0, 1, 16'd645);
        tick_n(59);
        check("g2_time1", 32'(if4.timeLeft), 1);
        pulse(0, 0, 1, 1, 16'd5);
        check("g2_eval_money", 32'(if4.money), 650);
        cycle();
        check("g2_passed", 32'(if4.stagePassed), 1);
        pulse(1, 0, 0, 0, 16'd0);              // startGame ignored in PASSED
        check("g2_ign_start_p", 32'(if4.stagePassed), 1);
        check("g2_ign_start_l", 32'(if4.loadPulse), 0);
        pulse(0, 1, 0, 0, 16'd0);
        check("l1_load",   32'(if4.loadPulse), 1);
        check("l1_lvl",    32'(if4.levelIndex), 1);
        check("l1_target", 32'(if4.target), 1050);
        check("l1_money",  32'(if4.money), 650);
        check("l1_time",   32'(if4.timeLeft), 60);
        check("l1_passed", 32'(if4.stagePassed), 0);

        // Level 1: saturation, then early end via allCollected
        cycle();
        tick_n(40);
        check("l1_time20", 32'(if4.timeLeft), 20);
        pulse(0, 0, 0, 1, 16'd64000);
        check("sat_a", 32'(if4.money), 64650);
        pulse(0, 0, 0, 1, 16'd2000);
        check("sat_b", 32'(if4.money), 65535);
        pulse(0, 0, 0, 1, 16'hFFFF);
        check("sat_c",  32'(if4.money), 65535);
        check("sat_c2", 32'(if2.money), 65535);
        all_collected = 1;
        cycle();
        all_collected = 0;
        check("ac_time", 32'(if4.timeLeft), 20);
        check("ac_en",   32'(if4.levelEnable), 0);
        cycle();
        check("l1_pass4", 32'(if4.stagePassed), 1);
        check("l1_pass2", 32'(if2.stagePassed), 1);
        cycle();
        check("done2_last",  32'(if2.lastLevelEnded), 1);
        check("done2_pass",  32'(if2.stagePassed), 0);
        check("still4_pass", 32'(if4.stagePassed), 1);
        check("still4_last", 32'(if4.lastLevelEnded), 0);
        pulse(0, 1, 0, 0, 16'd0);
        check("done2_ign_lvl",  32'(if2.levelIndex), 1);
        check("done2_ign_load", 32'(if2.loadPulse), 0);
        check("done2_ign_last", 32'(if2.lastLevelEnded), 1);
        check("l2_lvl",    32'(if4.levelIndex), 2);
        check("l2_target", 32'(if4.target), 1450);
        check("l2_load",   32'(if4.loadPulse), 1);

        // Full 60-second level with a single delivery of 700
        resetN = 0;
        #2;
        resetN = 1;
        cycle();
        pulse(1, 0, 0, 0, 16'd0);
        check("g3_load", 32'(if4.loadPulse), 1);
        check("g3_en0",  32'(if4.levelEnable), 0);
        check("g3_time", 32'(if4.timeLeft), 60);
        en_cnt = 0;
        cycle();
        check("g3_load_off", 32'(if4.loadPulse), 0);
        en_cnt += 32'(if4.levelEnable);
        for (int i = 0; i < 10; i++) begin
            pulse(0, 0, 1, 0, 16'd0);
            en_cnt += 32'(if4.levelEnable);
        end
        check("g3_time50", 32'(if4.timeLeft), 50);
        pulse(0, 0, 0, 1, 16'd700);
        en_cnt += 32'(if4.levelEnable);
        for (int i = 0; i < 50; i++) begin
            pulse(0, 0, 1, 0, 16'd0);
            en_cnt += 32'(if4.levelEnable);
        end
        // Samples with the enable high: 1 entering PLAY, 10 ticks, 1 collect, then ticks 11..59.
        check("g3_en_cycles", 32'(en_cnt), 61);
        check("g3_time0",     32'(if4.timeLeft), 0);
        check("g3_eval_pass", 32'(if4.stagePassed), 0);
        cycle();
        check("g3_passed", 32'(if4.stagePassed), 1);
        check("g3_money",  32'(if4.money), 700);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
